// File: rtl/pipeline_controller.sv
// pipeline_controller: stall / flush / PC-redirect sequencing for an in-order
// pipeline. Arbitrates peripheral (Wishbone) stalls, branch mispredicts and
// load-use hazards, with a sticky watchdog on long peripheral waits.
// Build option: define PIPE_PERF_CNT_EN to build the stall/flush/redirect
// performance counters; otherwise the counter ports read constant zero.
module pipeline_controller (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_stall_i,
  input  logic        branch_mispredict_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        peripheral_stall_i,
  output logic        stall_if_o,
  output logic        stall_id_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        pc_redirect_en_o,
  output logic [31:0] pc_redirect_o,
  output logic [1:0]  state_o,
  output logic        periph_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN         = 2'b00,
    ST_LOAD_BUBBLE = 2'b01,
    ST_REDIRECT    = 2'b10,
    ST_PERIPH_WAIT = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Event decode shared by next-state and output logic.
  // A latched redirect is only released on the first non-stalled PERIPH_WAIT
  // cycle; it beats a live mispredict arriving in that same cycle because the
  // older mispredict is the architecturally earlier one.
  // Load hazards are ignored in LOAD_BUBBLE (bubble already inserted) and in
  // REDIRECT (the ID stage holds a squashed instruction).
  logic issue_pending;
  logic take_redirect;
  logic load_honored;
  logic take_load;
  logic [31:0] redirect_target;

  assign issue_pending   = (state_q == ST_PERIPH_WAIT) && !peripheral_stall_i && pending_valid_q;
  assign take_redirect   = !peripheral_stall_i && (issue_pending || branch_mispredict_i);
  assign load_honored    = (state_q == ST_RUN) || (state_q == ST_PERIPH_WAIT);
  assign take_load       = !peripheral_stall_i && !take_redirect && load_stall_i && load_honored;
  assign redirect_target = issue_pending ? pending_pc_q : redirect_pc_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection in fixed priority: peripheral, redirect, load.
  always_comb begin
    state_d = ST_RUN;
    if (peripheral_stall_i) begin
      state_d = ST_PERIPH_WAIT;
    end else if (take_redirect) begin
      state_d = ST_REDIRECT;
    end else if (take_load) begin
      state_d = ST_LOAD_BUBBLE;
    end
  end

  // Outputs from state plus live inputs; everything forced quiet during reset.
  always_comb begin
    stall_if_o       = 1'b0;
    stall_id_o       = 1'b0;
    flush_if_o       = 1'b0;
    flush_id_o       = 1'b0;
    pc_redirect_en_o = 1'b0;
    pc_redirect_o    = 32'h0;
    if (!rst_i) begin
      if (peripheral_stall_i) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
      end else if (take_redirect) begin
        pc_redirect_en_o = 1'b1;
        pc_redirect_o    = redirect_target;
        flush_if_o       = 1'b1;
        flush_id_o       = 1'b1;
      end else if (take_load) begin
        stall_if_o = 1'b1;
        flush_id_o = 1'b1;
      end else if (state_q == ST_REDIRECT) begin
        flush_if_o = 1'b1;
      end
    end
  end

  // Pending-redirect capture: a mispredict hidden by a peripheral stall is
  // remembered (first one wins) and dropped once it has been issued.
  always_comb begin
    pending_valid_d = pending_valid_q;
    pending_pc_d    = pending_pc_q;
    if (peripheral_stall_i && branch_mispredict_i && !pending_valid_q) begin
      pending_valid_d = 1'b1;
      pending_pc_d    = redirect_pc_i;
    end else if (issue_pending) begin
      pending_valid_d = 1'b0;
    end
  end

  // Watchdog: saturating run length of consecutive PERIPH_WAIT cycles; clears
  // whenever the wait ends. The timeout flag is sticky until reset.
  always_comb begin
    wd_cnt_d = 8'h00;
    if ((state_q == ST_PERIPH_WAIT) && peripheral_stall_i) begin
      wd_cnt_d = (wd_cnt_q == 8'hFF) ? 8'hFF : wd_cnt_q + 8'h01;
    end
    timeout_d = timeout_q || (wd_cnt_d == 8'hFF);
  end

  // Pending-redirect and watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_valid_q <= 1'b0;
      pending_pc_q    <= 32'h0;
      wd_cnt_q        <= 8'h00;
      timeout_q       <= 1'b0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_pc_q    <= pending_pc_d;
      wd_cnt_q        <= wd_cnt_d;
      timeout_q       <= timeout_d;
    end
  end

  assign state_o          = state_q;
  assign periph_timeout_o = timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, redirect_cnt_q;

  // Performance counters, free-running and wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q    <= 32'h0;
      flush_cnt_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      if (stall_if_o)       stall_cnt_q    <= stall_cnt_q + 32'd1;
      if (flush_id_o)       flush_cnt_q    <= flush_cnt_q + 32'd1;
      if (pc_redirect_en_o) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`else
  assign stall_cnt_o    = 32'h0;
  assign flush_cnt_o    = 32'h0;
  assign redirect_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios with literal expectations
// followed by random traffic, all checked every cycle against a decision-table
// reference model.
module tb_pipeline_controller;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_stall = 1'b0;
  logic        mis = 1'b0;
  logic [31:0] rpc = 32'h0;
  logic        periph = 1'b0;
  logic        stall_if, stall_id, flush_if, flush_id, red_en, timeout;
  logic [31:0] red_pc, stall_cnt, flush_cnt, red_cnt;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .load_stall_i       (load_stall),
    .branch_mispredict_i(mis),
    .redirect_pc_i      (rpc),
    .peripheral_stall_i (periph),
    .stall_if_o         (stall_if),
    .stall_id_o         (stall_id),
    .flush_if_o         (flush_if),
    .flush_id_o         (flush_id),
    .pc_redirect_en_o   (red_en),
    .pc_redirect_o      (red_pc),
    .state_o            (state),
    .periph_timeout_o   (timeout),
    .stall_cnt_o        (stall_cnt),
    .flush_cnt_o        (flush_cnt),
    .redirect_cnt_o     (red_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 run, 1 after-load-bubble, 2 just-redirected, 3 waiting on peripheral
  int          m_mode;
  bit          m_pend_v;
  logic [31:0] m_pend_pc;
  int          m_run;
  bit          m_flag;
  logic [31:0] m_sc, m_fc, m_rc;

  task automatic model_reset();
    m_mode = 0; m_pend_v = 0; m_pend_pc = 0; m_run = 0; m_flag = 0;
    m_sc = 0; m_fc = 0; m_rc = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit          e_sif, e_sid, e_fif, e_fid, e_en;
    logic [31:0] e_pc;
    bit          use_pend, redir, ld;
    if (armed) begin
      e_sif = 0; e_sid = 0; e_fif = 0; e_fid = 0; e_en = 0; e_pc = 0;
      use_pend = !rst && !periph && (m_mode == 3) && m_pend_v;
      redir    = !rst && !periph && (use_pend || mis);
      ld       = !rst && !periph && !redir && load_stall && (m_mode == 0 || m_mode == 3);
      if (!rst) begin
        if (periph) begin
          e_sif = 1; e_sid = 1;
        end else if (redir) begin
          e_en = 1; e_fif = 1; e_fid = 1;
          e_pc = use_pend ? m_pend_pc : rpc;
        end else if (ld) begin
          e_sif = 1; e_fid = 1;
        end else if (m_mode == 2) begin
          e_fif = 1;
        end
      end
      chk("ctrl{sif,sid,fif,fid,en}", {27'h0, stall_if, stall_id, flush_if, flush_id, red_en},
          {27'h0, e_sif, e_sid, e_fif, e_fid, e_en});
      if (e_en || rst) chk("redirect_pc", red_pc, e_pc);
      chk("stall_id&flush_id", {31'h0, stall_id & flush_id}, 32'h0);
      chk("state", {30'h0, state}, m_mode);
      chk("timeout", {31'h0, timeout}, {31'h0, m_flag});
      chk("stall_cnt", stall_cnt, PERF ? m_sc : 32'h0);
      chk("flush_cnt", flush_cnt, PERF ? m_fc : 32'h0);
      chk("redirect_cnt", red_cnt, PERF ? m_rc : 32'h0);
      // advance model to the next edge
      if (rst) begin
        model_reset();
      end else begin
        m_sc += {31'h0, e_sif};
        m_fc += {31'h0, e_fid};
        m_rc += {31'h0, e_en};
        if (periph && mis && !m_pend_v) begin
          m_pend_v = 1; m_pend_pc = rpc;
        end else if (use_pend) begin
          m_pend_v = 0;
        end
        if (m_mode == 3 && periph) m_run = (m_run < 255) ? m_run + 1 : 255;
        else m_run = 0;
        if (m_run == 255) m_flag = 1;
        m_mode = periph ? 3 : redir ? 2 : ld ? 1 : 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit p, input bit m, input bit l, input logic [31:0] pc);
    @(posedge clk);
    #1;
    rst = r; periph = p; mis = m; load_stall = l; rpc = pc;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0);
  endtask

  function automatic logic [31:0] ctrl_vec();
    return {27'h0, stall_if, stall_id, flush_if, flush_id, red_en};
  endfunction

  initial begin
    int burst;
    bit r, p, m, l;
    // reset
    @(posedge clk);
    #1 armed = 1'b1;
    drive(1, 0, 0, 0, 32'h0);
    idle();
    @(negedge clk);
    chk("reset state", {30'h0, state}, 32'h0);
    chk("reset stall_cnt", stall_cnt, 32'h0);
    $display("reset released");

    // load stall
    drive(0, 0, 0, 1, 32'h0);
    @(negedge clk);
    chk("load ctrl", ctrl_vec(), 32'h12);
    idle();
    @(negedge clk);
    chk("load bubble state", {30'h0, state}, 32'h1);
    chk("load bubble ctrl", ctrl_vec(), 32'h0);
    idle();
    @(negedge clk);
    chk("load return state", {30'h0, state}, 32'h0);
    $display("load stall scenario done");

    // mispredict
    drive(0, 0, 1, 0, 32'h0000_0100);
    @(negedge clk);
    chk("mispredict ctrl", ctrl_vec(), 32'h07);
    chk("mispredict pc", red_pc, 32'h0000_0100);
    idle();
    @(negedge clk);
    chk("redirect state", {30'h0, state}, 32'h2);
    chk("redirect ctrl", ctrl_vec(), 32'h04);
    idle();
    @(negedge clk);
    chk("redirect return state", {30'h0, state}, 32'h0);
    chk("perf stall", stall_cnt, PERF ? 32'd1 : 32'd0);
    chk("perf flush", flush_cnt, PERF ? 32'd2 : 32'd0);
    chk("perf redirect", red_cnt, PERF ? 32'd1 : 32'd0);
    $display("mispredict scenario done");

    // simultaneous load + mispredict
    drive(0, 0, 1, 1, 32'h0000_0044);
    @(negedge clk);
    chk("simul ctrl", ctrl_vec(), 32'h07);
    idle();
    @(negedge clk);
    chk("simul state", {30'h0, state}, 32'h2);
    idle();
    $display("simultaneous event scenario done");

    // pending redirect across a 5-cycle peripheral stall
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 1, 0, 32'h0000_0200);
    drive(0, 1, 1, 0, 32'h0000_0300);
    drive(0, 1, 0, 0, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    @(negedge clk);
    chk("periph ctrl", ctrl_vec(), 32'h18);
    idle();
    @(negedge clk);
    chk("pending issue ctrl", ctrl_vec(), 32'h07);
    chk("pending issue pc", red_pc, 32'h0000_0200);
    idle();
    idle();
    $display("pending redirect scenario done");

    // watchdog then reset mid-wait
    for (int i = 1; i <= 300; i++) begin
      drive(0, 1, 0, 0, 32'h0);
      if (i == 200) begin
        @(negedge clk);
        chk("watchdog early", {31'h0, timeout}, 32'h0);
      end
    end
    @(negedge clk);
    chk("watchdog set", {31'h0, timeout}, 32'h1);
    drive(1, 1, 1, 1, 32'h0000_0500);
    @(negedge clk);
    chk("reset ctrl", ctrl_vec(), 32'h0);
    chk("reset pc", red_pc, 32'h0);
    drive(0, 1, 0, 0, 32'h0);
    @(negedge clk);
    chk("post-reset state", {30'h0, state}, 32'h0);
    chk("post-reset flag", {31'h0, timeout}, 32'h0);
    idle();
    idle();
    $display("watchdog/reset scenario done");

    // random traffic
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      if (burst > 0) begin
        p = 1; burst--;
      end else if ($urandom_range(7) == 0) begin
        p = 1; burst = $urandom_range(8);
      end else begin
        p = 0;
      end
      r = ($urandom_range(63) == 0);
      m = ($urandom_range(5) == 0);
      l = ($urandom_range(3) == 0);
      drive(r, p, m, l, $urandom);
    end
    idle();
    idle();
    $display("random traffic done");

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
